// File: rtl/fetch_pkg.sv
// Shared types, constants and PC helpers for the instruction fetch stage.
// Optional performance counters are enabled with INSTR_FETCH_PERF_EN.
package fetch_pkg;

  localparam int ROM_SIZE = 256;
  localparam int INSTR_W  = 9;
  localparam int ADDR_W   = $clog2(ROM_SIZE) + 1;
  localparam logic [INSTR_W-1:0] HALT_INSTR = 9'b111000000;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  // Sequential PC: the last ROM word is followed by word 0.
  function automatic addr_t next_pc(input addr_t pc);
    return (pc == addr_t'(ROM_SIZE - 1)) ? '0 : pc + 1'b1;
  endfunction

  // Redirect targets beyond the ROM fold back into it.
  function automatic addr_t mask_addr(input addr_t addr);
    return ADDR_W'(int'(addr) % ROM_SIZE);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// ROM bus and IF/ID register outputs of the fetch stage.
// master = fetch stage, slave = ROM + decode side.
interface instr_fetch_if;
  import fetch_pkg::*;

  addr_t  instr_addr;
  instr_t instr_in;
  instr_t ifid_instr;
  addr_t  ifid_pc;
  logic   ifid_valid;

  modport master (
    output instr_addr,
    input  instr_in,
    output ifid_instr,
    output ifid_pc,
    output ifid_valid
  );

  modport slave (
    input  instr_addr,
    output instr_in,
    input  ifid_instr,
    input  ifid_pc,
    input  ifid_valid
  );

endinterface

// File: rtl/fetch_perf_ctr.sv
// Pair of saturating 16-bit event counters for the fetch stage; only
// instantiated when INSTR_FETCH_PERF_EN is defined.
module fetch_perf_ctr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        fetch_inc,
  input  logic        bubble_inc,
  output logic [15:0] fetch_count,
  output logic [15:0] bubble_count
);

  // Count fetches and bubbles, sticking at all-ones; start clears both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else if (clr) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (fetch_inc && (fetch_count != 16'hFFFF))
        fetch_count <= fetch_count + 16'd1;
      if (bubble_inc && (bubble_count != 16'hFFFF))
        bubble_count <= bubble_count + 16'd1;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, addresses the async-read ROM and
// registers the returned word into IF/ID. Handles start, stall, branch
// redirect with flush, and halt detection.
// Define INSTR_FETCH_PERF_EN to add fetch_count/bubble_count outputs.
module instr_fetch
  import fetch_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  addr_t                start_addr,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  addr_t                branch_target,
  instr_fetch_if.master        bus,
  output logic                 running,
  output logic                 done
`ifdef INSTR_FETCH_PERF_EN
  ,
  output logic [15:0]          fetch_count,
  output logic [15:0]          bubble_count
`endif
);

  fetch_state_e state_q, state_d;
  addr_t        pc_q, pc_d;
  instr_t       ifid_instr_q, ifid_instr_d;
  addr_t        ifid_pc_q, ifid_pc_d;
  logic         ifid_valid_q, ifid_valid_d;

  // State, PC and IF/ID registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  // Next-state and next-register logic; priority in RUN is
  // branch > stall > halt > normal fetch.
  always_comb begin
    // NOTE: every output gets a hold default first so no path through the
    // case leaves a signal unassigned, which would infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;

    unique case (state_q)
      IDLE: begin
        ifid_valid_d = 1'b0;
        if (start) begin
          pc_d    = start_addr;
          state_d = RUN;
        end
      end

      RUN: begin
        if (branch_taken) begin
          // Wrong-path word (even a halt) is discarded.
          pc_d         = mask_addr(branch_target);
          ifid_valid_d = 1'b0;
        end else if (stall) begin
          // Hold everything for decode back-pressure.
        end else if (bus.instr_in == HALT_INSTR) begin
          ifid_instr_d = bus.instr_in;
          ifid_pc_d    = pc_q;
          ifid_valid_d = 1'b1;
          state_d      = HALTED;
        end else begin
          ifid_instr_d = bus.instr_in;
          ifid_pc_d    = pc_q;
          ifid_valid_d = 1'b1;
          pc_d         = next_pc(pc_q);
        end
      end

      HALTED: begin
        if (start) begin
          pc_d         = start_addr;
          ifid_valid_d = 1'b0;
          state_d      = RUN;
        end else if (!stall) begin
          ifid_valid_d = 1'b0;
        end
      end

      default: begin
        state_d      = IDLE;
        ifid_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.instr_addr = pc_q;
  assign bus.ifid_instr = ifid_instr_q;
  assign bus.ifid_pc    = ifid_pc_q;
  assign bus.ifid_valid = ifid_valid_q;

  assign running = (state_q == RUN);
  assign done    = (state_q == HALTED);

`ifdef INSTR_FETCH_PERF_EN
  logic ctr_clr, fetch_inc, bubble_inc;

  // A start only counts when it is accepted (not ignored in RUN).
  assign ctr_clr    = start && (state_q != RUN);
  assign fetch_inc  = (state_q == RUN) && !branch_taken && !stall;
  assign bubble_inc = (state_q == RUN) && (branch_taken || stall);

  fetch_perf_ctr u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (ctr_clr),
    .fetch_inc    (fetch_inc),
    .bubble_inc   (bubble_inc),
    .fetch_count  (fetch_count),
    .bubble_count (bubble_count)
  );
`endif

endmodule
